// File: rtl/instruction_fetch.sv
// instruction_fetch: single-issue fetch stage for a synchronous-read (1-cycle latency) instruction memory.
// Define DELAY_SLOT_EN to deliver the word fetched behind a taken branch (MIPS delay slot) instead of squashing it.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectAddress,
  output logic        memReadEnable,
  output logic [31:0] memAddress,
  input  logic [31:0] memReadData,
  output logic [31:0] instructionData,
  output logic        instructionValid,
  output logic [31:0] pc,
  output logic [31:0] nextPCAddress
);

`ifdef DELAY_SLOT_EN
  localparam logic        DELAY_SLOT  = 1'b1;
  localparam logic [31:0] LINK_OFFSET = 32'd8;
`else
  localparam logic        DELAY_SLOT  = 1'b0;
  localparam logic [31:0] LINK_OFFSET = 32'd4;
`endif

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_word_q, hold_word_d;
  logic        squash_q, squash_d;

  logic        advance;
  logic        redirect_take;
  logic        read_en;
  logic        insn_valid;
  logic [31:0] insn_data;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    hold_word_d = hold_word_q;
    squash_d    = 1'b0;
    advance     = 1'b0;
    insn_valid  = 1'b0;
    insn_data   = 32'h0;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        advance = 1'b1;
      end
      RUN: begin
        insn_valid = !squash_q;
        insn_data  = squash_q ? 32'h0 : memReadData;
        // A squashed bubble is never held: stall only freezes a real instruction.
        if (stall && insn_valid) begin
          state_d     = HOLD;
          hold_word_d = memReadData;
        end else begin
          advance = 1'b1;
        end
      end
      HOLD: begin
        insn_valid = 1'b1;
        insn_data  = hold_word_q;
        if (!stall) begin
          state_d = RUN;
          advance = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    // Stall has already blocked 'advance', so it wins over redirect.
    redirect_take = advance && insn_valid && redirect;
    read_en       = advance;

    if (advance) begin
      pc_d = fetch_pc_q;
      if (redirect_take) begin
        fetch_pc_d = {redirectAddress[31:2], 2'b00};
        squash_d   = !DELAY_SLOT;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_VECTOR;
      pc_q        <= RESET_VECTOR;
      hold_word_q <= 32'h0;
      squash_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      hold_word_q <= hold_word_d;
      squash_q    <= squash_d;
    end
  end

  // BOOT requests the reset vector, but no read may be issued while reset is still held.
  assign memReadEnable    = read_en && rst;
  assign memAddress       = fetch_pc_q;
  assign instructionData  = insn_data;
  assign instructionValid = insn_valid;
  assign pc               = pc_q;
  assign nextPCAddress    = pc_q + LINK_OFFSET;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized stall/redirect/reset traffic, checked every
// cycle against a presented-instruction/next-address model. Build with DELAY_SLOT_EN to test that variant.
`timescale 1ns/1ps
module tb_instruction_fetch;

  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef DELAY_SLOT_EN
  localparam bit          DS   = 1'b1;
  localparam logic [31:0] LINK = 32'd8;
`else
  localparam bit          DS   = 1'b0;
  localparam logic [31:0] LINK = 32'd4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_address = 32'h0;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] next_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirectAddress (redirect_address),
    .memReadEnable   (mem_re),
    .memAddress      (mem_addr),
    .memReadData     (mem_rdata),
    .instructionData (instr_data),
    .instructionValid(instr_valid),
    .pc              (pc),
    .nextPCAddress   (next_pc)
  );

  // Memory word n holds n; cycles without a read return junk so stale data is caught.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a >> 2;
  endfunction

  always @(posedge clk) mem_rdata <= mem_re ? word_at(mem_addr) : 32'($urandom());

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently presented (address, validity) and the next address to fetch.
  bit          m_boot  = 1'b1;
  bit          m_valid = 1'b0;
  logic [31:0] m_cur   = RV;
  logic [31:0] m_next  = RV;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_boot  = 1'b1;
      m_valid = 1'b0;
      m_cur   = RV;
      m_next  = RV;
    end else if (m_boot) begin
      m_boot  = 1'b0;
      m_cur   = m_next;
      m_valid = 1'b1;
      m_next  = m_next + 32'd4;
    end else if (!(stall && m_valid)) begin
      if (m_valid && redirect) begin
        m_cur   = m_next;
        m_valid = DS;
        m_next  = {redirect_address[31:2], 2'b00};
      end else begin
        m_cur   = m_next;
        m_valid = 1'b1;
        m_next  = m_next + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_data", instr_data, 32'h0);
      check("rst_read_en", 32'(mem_re), 32'd0);
      check("rst_pc", pc, RV);
      check("rst_mem_addr", mem_addr, RV);
    end else if (m_boot) begin
      check("boot_valid", 32'(instr_valid), 32'd0);
      check("boot_read_en", 32'(mem_re), 32'd1);
      check("boot_mem_addr", mem_addr, m_next);
    end else begin
      check("valid", 32'(instr_valid), 32'(m_valid));
      if (m_valid) begin
        check("data", instr_data, word_at(m_cur));
        check("pc", pc, m_cur);
        check("link", next_pc, m_cur + LINK);
      end else begin
        check("squash_data", instr_data, 32'h0);
      end
      check("read_en", 32'(mem_re), 32'(!(stall && m_valid)));
      if (!(stall && m_valid)) check("mem_addr", mem_addr, m_next);
    end
  end

  task automatic nc(input bit st, input bit rd, input logic [31:0] ra);
    @(posedge clk);
    #1;
    stall            = st;
    redirect         = rd;
    redirect_address = ra;
    @(negedge clk);
  endtask

  task automatic expect_insn(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_data);
    check({name, "_valid"}, 32'(instr_valid), 32'd1);
    check({name, "_pc"}, pc, exp_pc);
    check({name, "_data"}, instr_data, exp_data);
  endtask

  initial begin
    #12;
    check("t_rst_valid", 32'(instr_valid), 32'd0);
    check("t_rst_re", 32'(mem_re), 32'd0);
    check("t_rst_pc", pc, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t_boot_re", 32'(mem_re), 32'd1);
    check("t_boot_valid", 32'(instr_valid), 32'd0);

    nc(0, 0, 0); expect_insn("t_seq0", 32'h0, 32'd0);
    nc(0, 0, 0); expect_insn("t_seq1", 32'h4, 32'd1);
    for (int i = 0; i < 3; i++) begin
      nc(1, 0, 0); expect_insn("t_stall", 32'h8, 32'd2);
      check("t_stall_re", 32'(mem_re), 32'd0);
    end
    nc(0, 0, 0); expect_insn("t_release", 32'h8, 32'd2);
    check("t_release_addr", mem_addr, 32'hC);
    nc(0, 0, 0); expect_insn("t_after_release", 32'hC, 32'd3);

    nc(1, 1, 32'h40); expect_insn("t_redir_stalled", 32'h10, 32'd4);
    nc(0, 0, 0); expect_insn("t_redir_held", 32'h10, 32'd4);
    nc(0, 1, 32'h40); expect_insn("t_redir", 32'h14, 32'd5);
    nc(0, 0, 0);
    if (DS) expect_insn("t_delay_slot", 32'h18, 32'd6);
    else begin
      check("t_squash_valid", 32'(instr_valid), 32'd0);
      check("t_squash_data", instr_data, 32'h0);
    end
    check("t_target_addr", mem_addr, 32'h40);
    nc(0, 0, 0); expect_insn("t_target", 32'h40, 32'h10);

    nc(0, 1, 32'hFFFF_FFFB); expect_insn("t_hi_redir", 32'h44, 32'h11);
    nc(0, 0, 0);
    nc(0, 0, 0); expect_insn("t_hi0", 32'hFFFF_FFF8, 32'h3FFF_FFFE);
    nc(0, 0, 0); expect_insn("t_hi1", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    check("t_wrap_link", next_pc, DS ? 32'h4 : 32'h0);
    check("t_wrap_fetch", mem_addr, 32'h0);
    nc(0, 0, 0); expect_insn("t_wrapped", 32'h0, 32'd0);

    for (int i = 1; i <= 8; i++) nc(i == 8, 0, 0);
    nc(1, 0, 0); expect_insn("t_hold20", 32'h20, 32'd8);
    #2 rst = 1'b0;
    #1;
    check("t_mid_rst_valid", 32'(instr_valid), 32'd0);
    check("t_mid_rst_data", instr_data, 32'h0);
    check("t_mid_rst_re", 32'(mem_re), 32'd0);
    check("t_mid_rst_pc", pc, 32'h0);
    stall = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    expect_insn("t_restart", 32'h0, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst              = ($urandom_range(0, 199) != 0);
      stall            = ($urandom_range(0, 99) < 30);
      redirect         = ($urandom_range(0, 99) < 20);
      redirect_address = ($urandom_range(0, 1) != 0) ? 32'($urandom()) : 32'($urandom_range(0, 255));
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
